// File: rtl/nes_alu_pkg.sv
// Shared types, mode encoding and flag bit positions for the NES ALU.
// The mode field is 5 bits wide; codes above ALU_CMP are reserved and produce a zero result.
package nes_alu_pkg;

    typedef logic [4:0] alu_mode_t;

    localparam alu_mode_t ALU_ADD = 5'd0;
    localparam alu_mode_t ALU_AND = 5'd1;
    localparam alu_mode_t ALU_OR  = 5'd2;
    localparam alu_mode_t ALU_EOR = 5'd3;
    localparam alu_mode_t ALU_SR  = 5'd4;
    localparam alu_mode_t ALU_SUB = 5'd5;
    localparam alu_mode_t ALU_CMP = 5'd6;

    localparam int FLG_N = 3;
    localparam int FLG_V = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 0;

    function automatic logic [3:0] pack_flags(
        input logic n,
        input logic v,
        input logic z,
        input logic c
    );
        logic [3:0] f;
        f        = 4'b0000;
        f[FLG_N] = n;
        f[FLG_V] = v;
        f[FLG_Z] = z;
        f[FLG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/nes_alu_adder8.sv
// 8-bit adder with carry-in, carry-out and two's-complement overflow.
// Purely combinational; callers invert b themselves to subtract.
module nes_alu_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       v
);

    logic [8:0] w_sum9;

    assign w_sum9 = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    assign sum    = w_sum9[7:0];
    assign cout   = w_sum9[8];
    // Overflow when both addends share a sign and the result's sign differs.
    assign v      = (a[7] == b[7]) & (sum[7] != a[7]);

endmodule

// File: rtl/nes_alu.sv
// 6502-style 8-bit ALU: combinational result/flags, plus a {N,V,Z,C} snapshot register.
// Zero-latency datapath independent of reset; flags_q loads on flag_en, cleared by sync reset.
module nes_alu
    import nes_alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      alu_a,
    input  logic [7:0]      alu_b,
    input  alu_mode_t       mode,
    input  logic            carry_in,
    input  logic            flag_en,
    output logic [7:0]      alu_out,
    output logic            carry_out,
    output logic            overflow,
    output logic            zero,
    output logic            sign,
    output logic [3:0]      flags_q
);

    logic       w_invert_b;
    logic [7:0] w_add_b;
    logic       w_add_cin;
    logic [7:0] w_add_sum;
    logic       w_add_cout;
    logic       w_add_v;

    logic [7:0] w_out;
    logic       w_c;
    logic       w_v;

    logic [3:0] r_flags;

    // SUB and CMP share the adder as a + ~b + cin; CMP always subtracts without borrow-in.
    assign w_invert_b = (mode == ALU_SUB) || (mode == ALU_CMP);
    assign w_add_b    = w_invert_b ? ~alu_b : alu_b;
    assign w_add_cin  = (mode == ALU_CMP) ? 1'b1 : carry_in;

    nes_alu_adder8 u_adder (
        .a    (alu_a),
        .b    (w_add_b),
        .cin  (w_add_cin),
        .sum  (w_add_sum),
        .cout (w_add_cout),
        .v    (w_add_v)
    );

    always_comb begin
        w_out = 8'h00;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (mode)
            ALU_ADD, ALU_SUB: begin
                w_out = w_add_sum;
                w_c   = w_add_cout;
                w_v   = w_add_v;
            end
            ALU_AND: w_out = alu_a & alu_b;
            ALU_OR:  w_out = alu_a | alu_b;
            ALU_EOR: w_out = alu_a ^ alu_b;
            ALU_SR: begin
                w_out = {carry_in, alu_a[7:1]};
                w_c   = alu_a[0];
            end
            ALU_CMP: begin
                w_out = w_add_sum;
                w_c   = w_add_cout;
            end
            default: begin
                w_out = 8'h00;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
        endcase
    end

    assign alu_out   = w_out;
    assign carry_out = w_c;
    assign overflow  = w_v;
    assign zero      = (w_out == 8'h00);
    assign sign      = w_out[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (flag_en) begin
            r_flags <= pack_flags(w_out[7], w_v, (w_out == 8'h00), w_c);
        end
    end

    assign flags_q = r_flags;

endmodule

// File: tb/tb_nes_alu.sv
// Self-checking bench for nes_alu: directed vectors, random datapath sweep, flags register.
module tb_nes_alu;

    logic       clk;
    logic       reset;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] mode;
    logic       carry_in;
    logic       flag_en;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       sign;
    logic [3:0] flags_q;

    int n_checks = 0;
    int n_fail   = 0;

    nes_alu dut (
        .clk       (clk),
        .reset     (reset),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .mode      (mode),
        .carry_in  (carry_in),
        .flag_en   (flag_en),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign),
        .flags_q   (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the arithmetic definition of each operation.
    function automatic void ref_alu(input int a, input int b, input int m, input int cin,
                                    output int out, output int c, output int v);
        int sa, sb, sr;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        out = 0; c = 0; v = 0;
        case (m)
            0: begin
                out = (a + b + cin) % 256;
                c   = (a + b + cin > 255) ? 1 : 0;
                sr  = sa + sb + cin;
                v   = (sr > 127 || sr < -128) ? 1 : 0;
            end
            1: out = a & b;
            2: out = a | b;
            3: out = a ^ b;
            4: begin
                out = cin * 128 + a / 2;
                c   = a % 2;
            end
            5: begin
                out = (a - b - (1 - cin) + 512) % 256;
                c   = (a - b - (1 - cin) >= 0) ? 1 : 0;
                sr  = sa - sb - (1 - cin);
                v   = (sr > 127 || sr < -128) ? 1 : 0;
            end
            6: begin
                out = (a - b + 256) % 256;
                c   = (a >= b) ? 1 : 0;
            end
            default: begin
                out = 0; c = 0; v = 0;
            end
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input int out, input int c, input int v);
        return {(out >= 128) ? 1'b1 : 1'b0, v[0], (out == 0) ? 1'b1 : 1'b0, c[0]};
    endfunction

    task automatic test_reset();
        logic [11:0] got, exp;
        reset = 1'b1; flag_en = 1'b1;
        alu_a = 8'hFF; alu_b = 8'h01; mode = 5'd0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (flags_q !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", flags_q);
        end
        got = {alu_out, carry_out, overflow, zero, sign};
        exp = {8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_comb_live: got %h expected %h", got, exp);
        end
        @(negedge clk);
        reset = 1'b0; flag_en = 1'b0;
    endtask

    typedef struct {
        logic [4:0] m;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] out;
        logic       c;
        logic       v;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[11];
        logic [11:0] got, exp;
        tbl[0]  = '{5'd0, 8'h50, 8'h50, 1'b0, 8'hA0, 1'b0, 1'b1};
        tbl[1]  = '{5'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{5'd5, 8'h50, 8'hB0, 1'b1, 8'hA0, 1'b0, 1'b1};
        tbl[3]  = '{5'd6, 8'h40, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{5'd6, 8'h3F, 8'h40, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[5]  = '{5'd4, 8'h81, 8'h00, 1'b1, 8'hC0, 1'b1, 1'b0};
        tbl[6]  = '{5'd4, 8'h81, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0};
        tbl[7]  = '{5'd1, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{5'd2, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[9]  = '{5'd3, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{5'd7, 8'hAB, 8'hCD, 1'b1, 8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            mode = tbl[i].m; alu_a = tbl[i].a; alu_b = tbl[i].b; carry_in = tbl[i].cin;
            #1;
            got = {alu_out, carry_out, overflow, zero, sign};
            exp = {tbl[i].out, tbl[i].c, tbl[i].v, (tbl[i].out == 8'h00), tbl[i].out[7]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL directed_%0d: got {out,C,V,Z,N}=%h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_flag_sequence();
        @(negedge clk);
        mode = 5'd0; alu_a = 8'hFF; alu_b = 8'h01; carry_in = 1'b0; flag_en = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (flags_q !== 4'b0011) begin
            n_fail++;
            $display("FAIL seq_load: got %b expected 0011", flags_q);
        end
        @(negedge clk);
        alu_a = 8'h50; alu_b = 8'h50; flag_en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (flags_q !== 4'b0011) begin
            n_fail++;
            $display("FAIL seq_hold: got %b expected 0011", flags_q);
        end
        @(negedge clk);
        reset = 1'b1; flag_en = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (flags_q !== 4'b0000) begin
            n_fail++;
            $display("FAIL seq_reset_wins: got %b expected 0000", flags_q);
        end
        @(negedge clk);
        reset = 1'b0; flag_en = 1'b0;
    endtask

    // Random operands/modes each cycle; checks combinational outputs and the flag register.
    task automatic test_random(input int iters);
        int out, c, v, m;
        logic [3:0]  exp_flags;
        logic [11:0] got, exp;
        exp_flags = flags_q;
        for (int i = 0; i < iters; i++) begin
            @(negedge clk);
            m = $urandom_range(0, 9);
            if (m > 6) m = $urandom_range(7, 31);
            mode     = m[4:0];
            alu_a    = 8'($urandom_range(0, 255));
            alu_b    = 8'($urandom_range(0, 255));
            carry_in = 1'($urandom_range(0, 1));
            flag_en  = 1'($urandom_range(0, 1));
            reset    = ($urandom_range(0, 15) == 0);
            ref_alu(alu_a, alu_b, m, carry_in, out, c, v);
            #1;
            got = {alu_out, carry_out, overflow, zero, sign};
            exp = {out[7:0], c[0], v[0], (out == 0), out[7]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_comb_%0d: mode=%0d a=%h b=%h cin=%b got %h expected %h",
                         i, m, alu_a, alu_b, carry_in, got, exp);
            end
            if (reset) exp_flags = 4'b0000;
            else if (flag_en) exp_flags = ref_flags(out, c, v);
            @(posedge clk); #1;
            n_checks++;
            if (flags_q !== exp_flags) begin
                n_fail++;
                $display("FAIL rand_flags_%0d: got %b expected %b", i, flags_q, exp_flags);
            end
        end
        @(negedge clk);
        reset = 1'b0; flag_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flag_en = 1'b0;
        alu_a = 8'h00; alu_b = 8'h00; mode = 5'd0; carry_in = 1'b0;
        test_reset();
        test_directed();
        test_flag_sequence();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
